// File: rtl/filter_mode_ctrl.sv
// filter_mode_ctrl
//   Sequencing controller for the pixel filter datapath. Command bytes from
//   the UART receiver select a filter code that is applied to `oper` only at
//   a frame start, so a frame is never rendered with mixed filters. An
//   auto-cycle mode steps through all filter codes every FRAMES_PER_STEP
//   frames.
//
// Parameters
//   FRAMES_PER_STEP : frames each filter is held in auto-cycle (1..65535)
//
// Ports
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   cmd_valid    in   one-cycle strobe, cmd_byte valid
//   cmd_byte     in   ASCII command byte
//   vsync        in   camera frame sync level, rising edge = frame start
//   oper         out  filter code to the datapath
//   auto_on      out  high while in auto-cycle mode
//   cmd_ack      out  one-cycle pulse, legal command accepted
//   cmd_err      out  one-cycle pulse, illegal command byte
//   mode_changed out  one-cycle pulse in the cycle oper takes a new value
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | oper stable, nothing queued
// PENDING | a filter code waits in pend_reg for the next frame start
// AUTO    | auto-cycle, oper advances every FRAMES_PER_STEP frames

module filter_mode_ctrl #(
    parameter int unsigned FRAMES_PER_STEP = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte,
    input  logic       vsync,
    output logic [7:0] oper,
    output logic       auto_on,
    output logic       cmd_ack,
    output logic       cmd_err,
    output logic       mode_changed
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        AUTO    = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(FRAMES_PER_STEP - 1);
    localparam logic [7:0]  CODE_PASS = 8'h30;

    state_t      state, state_nx;
    logic [7:0]  pend_reg, pend_nx;
    logic [7:0]  oper_nx;
    logic [15:0] cnt, cnt_nx;
    logic        vsync_q;
    logic        frame_start;
    logic        is_digit, cmd_digit, cmd_auto, cmd_stop;
    logic        ack_nx, err_nx;

    // Auto-cycle order: 1..8, then passthrough, then wrap to 1. Any code
    // outside the legal set restarts the cycle at 1.
    function automatic logic [7:0] next_code(input logic [7:0] c);
        logic [7:0] r;
        if (c == 8'h38)
            r = 8'h30;
        else if (c >= 8'h30 && c < 8'h38)
            r = c + 8'd1;
        else
            r = 8'h31;
        return r;
    endfunction

    assign frame_start = vsync & ~vsync_q;
    assign is_digit    = (cmd_byte >= 8'h30) && (cmd_byte <= 8'h38);
    assign cmd_digit   = cmd_valid & is_digit;
    assign cmd_auto    = cmd_valid & (cmd_byte == 8'h41);
    assign cmd_stop    = cmd_valid & (cmd_byte == 8'h53);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            oper         <= CODE_PASS;
            pend_reg     <= CODE_PASS;
            cnt          <= 16'd0;
            vsync_q      <= 1'b0;
            auto_on      <= 1'b0;
            cmd_ack      <= 1'b0;
            cmd_err      <= 1'b0;
            mode_changed <= 1'b0;
        end else begin
            state        <= state_nx;
            oper         <= oper_nx;
            pend_reg     <= pend_nx;
            cnt          <= cnt_nx;
            vsync_q      <= vsync;
            auto_on      <= (state_nx == AUTO);
            cmd_ack      <= ack_nx;
            cmd_err      <= err_nx;
            mode_changed <= (oper_nx != oper);
        end
    end

    always_comb begin
        state_nx = state;
        oper_nx  = oper;
        pend_nx  = pend_reg;
        cnt_nx   = cnt;
        ack_nx   = cmd_digit | cmd_auto | cmd_stop;
        err_nx   = cmd_valid & ~(is_digit | cmd_auto | cmd_stop);

        case (state)
            IDLE: begin
                if (cmd_digit) begin
                    pend_nx  = cmd_byte;
                    state_nx = PENDING;
                end else if (cmd_auto) begin
                    cnt_nx   = 16'd0;
                    state_nx = AUTO;
                end
            end

            PENDING: begin
                // The value queued before this edge belongs to this frame;
                // a digit arriving in the same cycle waits for the next one.
                if (frame_start) begin
                    oper_nx  = pend_reg;
                    state_nx = IDLE;
                end
                if (cmd_digit) begin
                    pend_nx  = cmd_byte;
                    state_nx = PENDING;
                end else if (cmd_auto) begin
                    cnt_nx   = 16'd0;
                    state_nx = AUTO;
                end
            end

            AUTO: begin
                // A command in a frame-start cycle wins; that step is skipped.
                if (cmd_digit) begin
                    pend_nx  = cmd_byte;
                    state_nx = PENDING;
                end else if (cmd_stop) begin
                    state_nx = IDLE;
                end else if (cmd_auto) begin
                    cnt_nx = 16'd0;
                end else if (frame_start) begin
                    if (cnt >= CNT_LAST) begin
                        cnt_nx  = 16'd0;
                        oper_nx = next_code(oper);
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_filter_mode_ctrl.sv
module tb_filter_mode_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       vsync;
    logic [7:0] oper;
    logic       auto_on;
    logic       cmd_ack;
    logic       cmd_err;
    logic       mode_changed;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0] snap_oper;
    logic       snap_mc;
    logic       snap_auto;
    logic [7:0] exp_oper;

    filter_mode_ctrl #(.FRAMES_PER_STEP(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_byte     (cmd_byte),
        .vsync        (vsync),
        .oper         (oper),
        .auto_on      (auto_on),
        .cmd_ack      (cmd_ack),
        .cmd_err      (cmd_err),
        .mode_changed (mode_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_byte  = b;
        step();
        cmd_valid = 1'b0;
        cmd_byte  = 8'h00;
    endtask

    // One frame: vsync high for 3 cycles, low for 2. The outputs right after
    // the first sampled-high edge are captured for the caller.
    task automatic frame();
        vsync = 1'b1;
        step();
        snap_oper = oper;
        snap_mc   = mode_changed;
        snap_auto = auto_on;
        step();
        step();
        vsync = 1'b0;
        step();
        step();
    endtask

    function automatic logic [7:0] model_next(input logic [7:0] c);
        if (c == 8'h38) return 8'h30;
        return c + 8'd1;
    endfunction

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_byte  = 8'h00;
        vsync     = 1'b0;
        step(); step(); step();
        chk("rst_oper", oper, 8'h30);
        chk("rst_auto", {7'd0, auto_on}, 8'd0);
        chk("rst_ack",  {7'd0, cmd_ack}, 8'd0);
        chk("rst_err",  {7'd0, cmd_err}, 8'd0);
        chk("rst_mc",   {7'd0, mode_changed}, 8'd0);
        rst_n = 1'b1;
        step();

        // Reset defaults: '3' then one frame
        send(8'h33);
        chk("ack_pulse", {7'd0, cmd_ack}, 8'd1);
        chk("oper_before_frame", oper, 8'h30);
        step();
        chk("ack_single", {7'd0, cmd_ack}, 8'd0);
        for (int i = 0; i < 5; i++) step();
        chk("oper_still_pass", oper, 8'h30);
        vsync = 1'b1;
        step();
        chk("oper_applied", oper, 8'h33);
        chk("mc_on_apply", {7'd0, mode_changed}, 8'd1);
        step();
        chk("mc_one_cycle", {7'd0, mode_changed}, 8'd0);
        step();
        chk("vsync_level_no_refire", oper, 8'h33);
        vsync = 1'b0;
        step();

        // Last command wins, illegal byte flagged
        send(8'h32);
        chk("err_after_2", {7'd0, cmd_err}, 8'd0);
        chk("no_032_early", oper, 8'h33);
        send(8'h35);
        chk("err_after_5", {7'd0, cmd_err}, 8'd0);
        send(8'h5A);
        chk("err_pulse", {7'd0, cmd_err}, 8'd1);
        chk("ack_on_err", {7'd0, cmd_ack}, 8'd0);
        step();
        chk("err_single", {7'd0, cmd_err}, 8'd0);
        frame();
        chk("last_wins", snap_oper, 8'h35);
        chk("last_wins_mc", {7'd0, snap_mc}, 8'd1);

        // Back to passthrough, then auto-cycle every 2nd frame
        send(8'h30);
        frame();
        chk("pass_before_auto", snap_oper, 8'h30);
        send(8'h41);
        chk("auto_rise", {7'd0, auto_on}, 8'd1);
        chk("auto_ack", {7'd0, cmd_ack}, 8'd1);
        exp_oper = 8'h30;
        for (int k = 1; k <= 26; k++) begin
            frame();
            if (k % 2 == 0) exp_oper = model_next(exp_oper);
            chk($sformatf("auto_oper_f%0d", k), snap_oper, exp_oper);
            chk($sformatf("auto_mc_f%0d", k), {7'd0, snap_mc}, {7'd0, (k % 2 == 0)});
            chk($sformatf("auto_on_f%0d", k), {7'd0, snap_auto}, 8'd1);
        end
        chk("auto_end_0x34", oper, 8'h34);

        // Stop holds the current code
        send(8'h53);
        chk("auto_fall_stop", {7'd0, auto_on}, 8'd0);
        for (int k = 0; k < 5; k++) begin
            frame();
            chk($sformatf("stop_hold_f%0d", k), snap_oper, 8'h34);
            chk($sformatf("stop_mc_f%0d", k), {7'd0, snap_mc}, 8'd0);
        end

        // Digit coincident with frame start while '1' is pending
        send(8'h31);
        cmd_valid = 1'b1;
        cmd_byte  = 8'h37;
        vsync     = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("collide_old_applied", oper, 8'h31);
        chk("collide_mc", {7'd0, mode_changed}, 8'd1);
        chk("collide_ack", {7'd0, cmd_ack}, 8'd1);
        step();
        vsync = 1'b0;
        step();
        frame();
        chk("collide_new_next", snap_oper, 8'h37);

        // Command in a frame-start cycle in AUTO skips that step
        send(8'h41);
        frame();
        chk("auto_cnt1_hold", snap_oper, 8'h37);
        cmd_valid = 1'b1;
        cmd_byte  = 8'h41;
        vsync     = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("auto_cmd_priority", oper, 8'h37);
        step();
        vsync = 1'b0;
        step();
        frame();
        chk("auto_restart_hold", snap_oper, 8'h37);
        frame();
        chk("auto_after_restart", snap_oper, 8'h38);

        // Digit in AUTO drops auto_on; identical code gives no pulse
        send(8'h38);
        chk("auto_fall_digit", {7'd0, auto_on}, 8'd0);
        frame();
        chk("same_code_oper", snap_oper, 8'h38);
        chk("same_code_no_mc", {7'd0, snap_mc}, 8'd0);

        // Reset with a command pending
        send(8'h35);
        rst_n = 1'b0;
        step();
        chk("midrst_oper", oper, 8'h30);
        rst_n = 1'b1;
        step();
        chk("postrst_oper", oper, 8'h30);
        chk("postrst_ack", {7'd0, cmd_ack}, 8'd0);
        chk("postrst_err", {7'd0, cmd_err}, 8'd0);
        chk("postrst_mc",  {7'd0, mode_changed}, 8'd0);
        chk("postrst_auto", {7'd0, auto_on}, 8'd0);
        frame();
        chk("pending_discarded", snap_oper, 8'h30);
        chk("pending_discarded_mc", {7'd0, snap_mc}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
